// File: rtl/pe_result_drain.sv
// Result drain for the 2x16 PE array: buffers whole result snapshots and
// serializes them as LANES-wide beats over a valid/ready stream. Snapshots
// arriving with no free slot are dropped and flagged in a sticky overflow bit.
module pe_result_drain #(
    parameter int DEPTH = 2,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [511:0]             pe_result,
    input  logic                     pe_valid,
    input  logic [3:0]               pe_tag,
    output logic [LANES*16-1:0]      out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_tag,
    output logic                     out_row,
    output logic [3:0]               out_col_base,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     overflow
);

    localparam int BEATS  = 32 / LANES;
    localparam int BPR    = 16 / LANES;   // beats per PE row
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BEATS);

    logic [511:0]      slot_data_q [DEPTH];
    logic [511:0]      slot_data_d [DEPTH];
    logic [3:0]        slot_tag_q  [DEPTH];
    logic [3:0]        slot_tag_d  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              ovf_q, ovf_d;

    logic hs;
    logic pop;
    logic slot_free;
    logic cap;
    logic drop;

    // Read side view: beat b covers flattened values b*LANES .. b*LANES+LANES-1,
    // which is row b/BPR starting at column (b%BPR)*LANES.
    always_comb begin
        int beat_idx;
        beat_idx     = int'(beat_q);
        out_data     = '0;
        out_valid    = (occ_q != '0);
        out_tag      = slot_tag_q[rd_ptr_q];
        out_row      = 1'(beat_idx / BPR);
        out_col_base = 4'((beat_idx % BPR) * LANES);
        out_last     = (beat_q == BEAT_W'(BEATS - 1));
        occupancy    = occ_q;
        full         = (occ_q == OCC_W'(DEPTH));
        overflow     = ovf_q;
        for (int k = 0; k < LANES; k++) begin
            out_data[k*16 +: 16] = slot_data_q[rd_ptr_q][(beat_idx*LANES + k)*16 +: 16];
        end
    end

    // Next-state: a last-beat pop frees its slot in the same cycle, so a
    // coincident capture is accepted even when the buffer is full.
    always_comb begin
        hs          = out_valid & out_ready;
        pop         = hs & out_last;
        slot_free   = ~full | pop;
        cap         = pe_valid & slot_free;
        drop        = pe_valid & ~slot_free;

        slot_data_d = slot_data_q;
        slot_tag_d  = slot_tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_d      = beat_q;
        occ_d       = occ_q;
        ovf_d       = ovf_q | drop;

        if (cap) begin
            slot_data_d[wr_ptr_q] = pe_result;
            slot_tag_d[wr_ptr_q]  = pe_tag;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        if (hs) begin
            if (out_last) begin
                beat_d   = '0;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                beat_d   = beat_q + BEAT_W'(1);
            end
        end

        case ({cap, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers; reset also clears slot storage so the read view is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_data_q[i] <= '0;
                slot_tag_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            slot_data_q <= slot_data_d;
            slot_tag_q  <= slot_tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_q      <= beat_d;
            occ_q       <= occ_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
